conv_window_gen: RTL and testbench
==================================

# conv_window_gen

Reader-side companion to the 4-row line buffer: consumes the live pixel stream plus the four delayed-row taps and assembles a sliding 5x5 convolution window for the LeNet conv stages. Tracks raster position per frame and flags only windows lying fully inside the image. Sits between the row buffer chain and the 5x5 multiply-accumulate array.

## Interface
- COLS, 28, image width in pixels; must match the line buffer depth; >= 5
- ROWS, 28, image height in pixels; >= 5
- BIT_WIDTH, 8, pixel width
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- en  input  1  pixel strobe; same signal drives the line buffer enable
- pix_in  input  BIT_WIDTH  current pixel (row r, col c)
- rb_out0..rb_out3  input  BIT_WIDTH each  line buffer taps: pixel (r-1-N, c) during an en cycle
- win_out  output  25*BIT_WIDTH  window; element (i,j), i,j in 0..4, at bits [(i*5+j)*BIT_WIDTH +: BIT_WIDTH] = pixel (r-4+i, c-4+j)
- win_valid  output  1  one-cycle pulse: win_out holds a complete in-image window
- frame_done  output  1  one-cycle pulse after the last pixel (ROWS-1, COLS-1) of a frame is accepted

## Operation
- Window storage: 5 rows x 5 columns of BIT_WIDTH registers. On each en cycle, every row shifts one column toward j=0; new column j=4 loaded top-to-bottom as {rb_out3, rb_out2, rb_out1, rb_out0, pix_in}.
- No change to window, counters or pulses when en=0; pipeline stalls indefinitely.
- col_cnt: 0..COLS-1, increments on en, wraps to 0 at COLS-1. row_cnt: 0..ROWS-1, increments on column wrap, wraps to 0 after (ROWS-1, COLS-1).
- win_valid asserted in the cycle after an en cycle whose accepted pixel had row_cnt >= 4 and col_cnt >= 4; otherwise 0. Exactly (ROWS-4)*(COLS-4) pulses per frame (576 at defaults).
- Windows straddling the left/right edge (col_cnt < 4) contain mixed-row data and are never flagged valid.
- frame_done and the final win_valid of a frame pulse in the same cycle.
- Line buffers carry no reset; after reset, garbage taps are harmless because valid is gated until row_cnt reaches 4, by which point the buffers hold the new frame.

## Timing
- Reset values: win_out all zero, win_valid 0, frame_done 0, row_cnt 0, col_cnt 0.
- Latency: en cycle accepting pixel (r,c) -> win_out and win_valid updated at the next rising edge (1 cycle). win_out remains stable until the next en.
- Back-to-back en: one window per cycle, full throughput.
- rst_n asserted mid-frame: immediate clear of all state; the next accepted pixel is treated as (0,0).
- Counter wrap and frame restart occur with no idle cycle; first pixel of the next frame may arrive the cycle after the last pixel of the current frame.

## Configuration
- CONV_WIN_CNT_EN defined: adds output win_cnt [15:0], number of valid windows issued in the current frame; increments with each win_valid, clears to 0 on reset and in the cycle after frame_done (so it reads (ROWS-4)*(COLS-4) while frame_done is high).
- Not defined: port and counter absent; all other behaviour identical.

## Test plan
- Reset: hold rst_n=0 with en toggling -> win_out=0, win_valid=0, frame_done=0 throughout.
- Full frame, defaults, pixel value = row*28+col mod 256, taps modelled by a reference line buffer, en=1 continuous -> exactly 576 win_valid pulses; first one after pixel (4,4) with element (0,0)=0 and (4,4)=116; frame_done coincides with the last one.
- Random en gaps (~50% duty), ROWS=COLS=8 -> 16 windows, contents identical to the continuous run; no change on en=0 cycles.
- Two frames back-to-back, ROWS=COLS=8 -> frame_done twice, 16 valid pulses each, first window of frame 2 matches frame-1 reference.
- rst_n pulse at pixel (10,7), then restart a frame -> no win_valid until new pixel (4,4); afterwards windows correct.
- CONV_WIN_CNT_EN defined, defaults -> win_cnt reads 576 when frame_done=1, 0 the next cycle.

Source files
------------

// File: rtl/conv_window_gen.sv
// Sliding 5x5 window builder fed by the live pixel and four line-buffer taps; flags in-image windows only.
// Optional CONV_WIN_CNT_EN adds a per-frame win_cnt output counting issued windows.
module conv_window_gen #(
  parameter int COLS      = 28,
  parameter int ROWS      = 28,
  parameter int BIT_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic [BIT_WIDTH-1:0]   pix_in,
  input  logic [BIT_WIDTH-1:0]   rb_out0,
  input  logic [BIT_WIDTH-1:0]   rb_out1,
  input  logic [BIT_WIDTH-1:0]   rb_out2,
  input  logic [BIT_WIDTH-1:0]   rb_out3,
  output logic [25*BIT_WIDTH-1:0] win_out,
  output logic                   win_valid,
  output logic                   frame_done
`ifdef CONV_WIN_CNT_EN
  ,
  output logic [15:0]            win_cnt
`endif
);

  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
  localparam logic [CW-1:0] COL_EDGE = CW'(4);
  localparam logic [RW-1:0] ROW_EDGE = RW'(4);

  logic [CW-1:0]          col_cnt_q, col_cnt_d;
  logic [RW-1:0]          row_cnt_q, row_cnt_d;
  logic [BIT_WIDTH-1:0]   win_q [5][5];
  logic [BIT_WIDTH-1:0]   win_d [5][5];
  logic [BIT_WIDTH-1:0]   new_col [5];
  logic                   win_valid_q, win_valid_d;
  logic                   frame_done_q, frame_done_d;
  logic                   col_wrap;

  // Oldest row sits at i=0, so the deepest tap enters the top of the new column.
  assign new_col[0] = rb_out3;
  assign new_col[1] = rb_out2;
  assign new_col[2] = rb_out1;
  assign new_col[3] = rb_out0;
  assign new_col[4] = pix_in;

  assign col_wrap = (col_cnt_q == COL_LAST);

  always_comb begin
    win_d        = win_q;
    col_cnt_d    = col_cnt_q;
    row_cnt_d    = row_cnt_q;
    win_valid_d  = 1'b0;
    frame_done_d = 1'b0;
    if (en) begin
      for (int i = 0; i < 5; i++) begin
        for (int j = 0; j < 4; j++) begin
          win_d[i][j] = win_q[i][j+1];
        end
        win_d[i][4] = new_col[i];
      end
      // Left-edge windows mix two rows of data, so both coordinates gate validity.
      win_valid_d  = (row_cnt_q >= ROW_EDGE) && (col_cnt_q >= COL_EDGE);
      frame_done_d = col_wrap && (row_cnt_q == ROW_LAST);
      if (col_wrap) begin
        col_cnt_d = '0;
        row_cnt_d = (row_cnt_q == ROW_LAST) ? '0 : row_cnt_q + 1'b1;
      end else begin
        col_cnt_d = col_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_cnt_q    <= '0;
      row_cnt_q    <= '0;
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      for (int i = 0; i < 5; i++) begin
        for (int j = 0; j < 5; j++) begin
          win_q[i][j] <= '0;
        end
      end
    end else begin
      col_cnt_q    <= col_cnt_d;
      row_cnt_q    <= row_cnt_d;
      win_valid_q  <= win_valid_d;
      frame_done_q <= frame_done_d;
      win_q        <= win_d;
    end
  end

  for (genvar gi = 0; gi < 5; gi++) begin : g_row
    for (genvar gj = 0; gj < 5; gj++) begin : g_col
      assign win_out[(gi*5+gj)*BIT_WIDTH +: BIT_WIDTH] = win_q[gi][gj];
    end
  end

  assign win_valid  = win_valid_q;
  assign frame_done = frame_done_q;

`ifdef CONV_WIN_CNT_EN
  logic [15:0] win_cnt_q, win_cnt_d;

  // Clear follows frame_done regardless of en so the total is visible for exactly one cycle.
  always_comb begin
    win_cnt_d = win_cnt_q;
    if (frame_done_q) begin
      win_cnt_d = '0;
    end
    if (win_valid_d) begin
      win_cnt_d = win_cnt_d + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_cnt_q <= '0;
    end else begin
      win_cnt_q <= win_cnt_d;
    end
  end

  assign win_cnt = win_cnt_q;
`endif

endmodule

// File: tb/tb_conv_window_gen.sv
// Directed bench for conv_window_gen with a reference line buffer and an expected-window scoreboard.
module tb_conv_window_gen;

  localparam int COLS = 28;
  localparam int ROWS = 28;
  localparam int BW   = 8;
  localparam int WW   = 25 * BW;
  localparam int NPIX = ROWS * COLS;
  localparam int NWIN = (ROWS - 4) * (COLS - 4);

  logic          clk;
  logic          rst_n;
  logic          en;
  logic [BW-1:0] pix_in;
  logic [BW-1:0] rb_out0, rb_out1, rb_out2, rb_out3;
  logic [WW-1:0] win_out;
  logic          win_valid;
  logic          frame_done;
`ifdef CONV_WIN_CNT_EN
  logic [15:0]   win_cnt;
`endif

  conv_window_gen #(.COLS(COLS), .ROWS(ROWS), .BIT_WIDTH(BW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .pix_in    (pix_in),
    .rb_out0   (rb_out0),
    .rb_out1   (rb_out1),
    .rb_out2   (rb_out2),
    .rb_out3   (rb_out3),
    .win_out   (win_out),
    .win_valid (win_valid),
    .frame_done(frame_done)
`ifdef CONV_WIN_CNT_EN
    ,
    .win_cnt   (win_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference line buffer: unreset shift chain, tap N is COLS*(N+1) accepted pixels old.
  logic [BW-1:0] lb [4*COLS];
  always @(posedge clk) begin
    if (en) begin
      lb[0] <= pix_in;
      for (int k = 1; k < 4*COLS; k++) lb[k] <= lb[k-1];
    end
  end
  assign rb_out0 = lb[1*COLS-1];
  assign rb_out1 = lb[2*COLS-1];
  assign rb_out2 = lb[3*COLS-1];
  assign rb_out3 = lb[4*COLS-1];

  int            n_assert;
  int            n_fail;
  int            rr, cc;
  int            vcount;
  int            cnt_m;
  bit            fd_prev;
  bit            last_exp_vld;
  logic [WW-1:0] last_exp;
  logic [WW-1:0] exp_q [$];

  function automatic logic [BW-1:0] pixval(input int r, input int c);
    return BW'((r * COLS + c) % 256);
  endfunction

  function automatic logic [WW-1:0] expwin(input int r, input int c);
    logic [WW-1:0] w;
    w = '0;
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++)
        w[(i*5+j)*BW +: BW] = pixval(r - 4 + i, c - 4 + j);
    return w;
  endfunction

  task automatic chk(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic clear_model();
    rr = 0; cc = 0; vcount = 0; cnt_m = 0;
    fd_prev = 1'b0; last_exp_vld = 1'b0;
    exp_q.delete();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_win_out"}, win_out, '0);
    chk({tag, "_win_valid"}, WW'(win_valid), '0);
    chk({tag, "_frame_done"}, WW'(frame_done), '0);
`ifdef CONV_WIN_CNT_EN
    chk({tag, "_win_cnt"}, WW'(win_cnt), '0);
`endif
  endtask

  // Hold reset for n cycles with en toggling, then release with the model re-zeroed.
  task automatic reset_hold(input int n);
    rst_n = 1'b0;
    repeat (n) begin
      en = 1'($urandom_range(0, 1));
      pix_in = BW'($urandom);
      @(posedge clk); #1;
      chk_zero("reset");
    end
    en = 1'b0;
    clear_model();
    rst_n = 1'b1;
  endtask

  task automatic step(input bit e);
    bit            ev, efd;
    int            er, ec;
    logic [WW-1:0] w;
    er = rr; ec = cc;
    ev  = e && (rr >= 4) && (cc >= 4);
    efd = e && (rr == ROWS-1) && (cc == COLS-1);
    en = e;
    pix_in = e ? pixval(rr, cc) : BW'($urandom);
    if (ev) exp_q.push_back(expwin(rr, cc));
    if (e) begin
      if (cc == COLS-1) begin
        cc = 0;
        rr = (rr == ROWS-1) ? 0 : rr + 1;
      end else begin
        cc++;
      end
    end
    if (fd_prev) cnt_m = 0;
    if (ev) cnt_m++;
    fd_prev = efd;

    @(posedge clk); #1;
    chk("win_valid", WW'(win_valid), WW'(ev));
    chk("frame_done", WW'(frame_done), WW'(efd));
`ifdef CONV_WIN_CNT_EN
    chk("win_cnt", WW'(win_cnt), WW'(cnt_m));
`endif
    if (win_valid === 1'b1) vcount++;
    if (ev) begin
      if (exp_q.size() == 0) begin
        chk("scoreboard_empty", WW'(1), WW'(0));
      end else begin
        w = exp_q.pop_front();
        chk("window", win_out, w);
        last_exp = w;
        if (er == 4 && ec == 4) begin
          chk("first_elem00", WW'(win_out[0 +: BW]), WW'(0));
          chk("first_elem44", WW'(win_out[24*BW +: BW]), WW'(116));
        end
      end
      last_exp_vld = 1'b1;
    end else if (e) begin
      last_exp_vld = 1'b0;
    end else if (last_exp_vld) begin
      chk("hold_window", win_out, last_exp);
    end
    if (efd) begin
      chk("valid_count", WW'(vcount), WW'(NWIN));
`ifdef CONV_WIN_CNT_EN
      chk("win_cnt_at_done", WW'(win_cnt), WW'(NWIN));
`endif
      vcount = 0;
    end
  endtask

  initial begin
    int accepted;
    int guard;
    bit e;
    n_assert = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    en       = 1'b0;
    pix_in   = '0;
    last_exp = '0;
    clear_model();

    reset_hold(6);

    // Frame A: continuous en.
    for (int p = 0; p < NPIX; p++) step(1'b1);

    // Frame B back-to-back with ~50% en gaps; first pixel lands right after frame A.
    step(1'b1);
    accepted = 1;
    guard = 0;
    while (accepted < NPIX && guard < 20000) begin
      e = 1'($urandom_range(0, 1));
      step(e);
      if (e) accepted++;
      guard++;
    end
    if (accepted < NPIX) chk("frame_b_budget", WW'(accepted), WW'(NPIX));

    repeat (3) step(1'b0);

    // Partial frame up to pixel (10,7), then an asynchronous mid-frame reset.
    for (int p = 0; p < 10*COLS + 7; p++) step(1'b1);
    rst_n = 1'b0;
    #1;
    chk_zero("midreset_immediate");
    reset_hold(3);

    // Frame C after reset: first valid must come only at new pixel (4,4).
    for (int p = 0; p < NPIX; p++) step(1'b1);
    repeat (2) step(1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
